// File: rtl/frame_sync_pkg.sv
// -----------------------------------------------------------------------------
// frame_sync_pkg
// Shared types and width helpers for the frame synchronisation controller.
//   state_e    : controller state (SEEK, ACTIVE, FLUSH)
//   err_code_e : framing error cause reported on o_err_code
//   cnt_w()    : counter width helper, never returns less than 1 bit
// -----------------------------------------------------------------------------
package frame_sync_pkg;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NO_SOF    = 2'd0,
    ERR_EARLY_EOL = 2'd1,
    ERR_NO_EOL    = 2'd2,
    ERR_UNEXP_SOF = 2'd3
  } err_code_e;

  // Width needed to count 0..n-1; a single-value counter still gets one bit.
  function automatic int cnt_w(input int n);
    int w;
    if (n <= 1) begin
      w = 1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/frame_pos_counter.sv
// -----------------------------------------------------------------------------
// frame_pos_counter
// Pixel position tracker (x within line, y within frame).
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   clear         : force position to (0,0); wins over advance
//   advance       : step to the next pixel, wrapping at line and frame end
//   at_sol        : x == 0
//   at_eol        : x == IMG_WIDTH-1
//   at_eof        : last pixel of the frame (x,y) == (IMG_WIDTH-1, IMG_HEIGHT-1)
//   first_line    : y == 0
// -----------------------------------------------------------------------------
module frame_pos_counter
  import frame_sync_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic clear,
  input  logic advance,
  output logic at_sol,
  output logic at_eol,
  output logic at_eof,
  output logic first_line
);

  localparam int X_W = cnt_w(IMG_WIDTH);
  localparam int Y_W = cnt_w(IMG_HEIGHT);
  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);

  logic [X_W-1:0] x_r;
  logic [Y_W-1:0] y_r;

  // Position register: raster-order step with wrap to (0,0) after the frame.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      x_r <= {X_W{1'b0}};
      y_r <= {Y_W{1'b0}};
    end else if (clear) begin
      x_r <= {X_W{1'b0}};
      y_r <= {Y_W{1'b0}};
    end else if (advance) begin
      if (x_r == X_LAST) begin
        x_r <= {X_W{1'b0}};
        if (y_r == Y_LAST) begin
          y_r <= {Y_W{1'b0}};
        end else begin
          y_r <= y_r + Y_W'(1);
        end
      end else begin
        x_r <= x_r + X_W'(1);
      end
    end
  end

  assign at_sol     = (x_r == {X_W{1'b0}});
  assign at_eol     = (x_r == X_LAST);
  assign first_line = (y_r == {Y_W{1'b0}});
  assign at_eof     = at_eol && (y_r == Y_LAST);

endmodule

// File: rtl/frame_sync_ctrl.sv
// -----------------------------------------------------------------------------
// frame_sync_ctrl
// AXIS stream-integrity controller between the camera FIFO and the pixel
// datapath. Beats pass through combinationally; framing violations or an
// external flush request pulse o_flush for FLUSH_CYCLES cycles, then input is
// discarded until the next start-of-frame, so downstream only sees whole frames.
//
// Ports:
//   i_clk, i_rstn                       clock, asynchronous active-low reset
//   i_flush                             synchronous external flush request
//   i_tdata/i_tvalid/i_tuser/i_tlast    upstream beat (tuser = SOF, tlast = EOL)
//   o_tready                            ready to upstream
//   o_tdata/o_tvalid/o_tuser/o_tlast    downstream beat
//   i_tready                            downstream ready
//   o_flush                             flush to processing datapath (registered)
//   o_frame_done                        one-cycle pulse after a good frame
//   o_frame_cnt                         good-frame count, wraps
//   o_err, o_err_code                   one-cycle error pulse and its cause
//   o_err_cnt, o_drop_cnt               saturating statistics
//
// Build option FRAME_STATS_EN: when defined, o_err_cnt/o_drop_cnt count errors
// and beats discarded while seeking; when undefined they are tied to zero.
// -----------------------------------------------------------------------------
module frame_sync_ctrl
  import frame_sync_pkg::*;
#(
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480,
  parameter int DATA_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 4,
  parameter int FCNT_WIDTH   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_tdata,
  input  logic                  i_tvalid,
  input  logic                  i_tuser,
  input  logic                  i_tlast,
  output logic                  o_tready,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tvalid,
  output logic                  o_tuser,
  output logic                  o_tlast,
  input  logic                  i_tready,
  output logic                  o_flush,
  output logic                  o_frame_done,
  output logic [FCNT_WIDTH-1:0] o_frame_cnt,
  output logic                  o_err,
  output logic [1:0]            o_err_code,
  output logic [FCNT_WIDTH-1:0] o_err_cnt,
  output logic [FCNT_WIDTH-1:0] o_drop_cnt
);

  localparam int FLUSH_W = cnt_w(FLUSH_CYCLES);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  state_e              state_r;
  state_e              state_nxt_s;
  logic [FLUSH_W-1:0]  flush_cnt_r;
  logic [FLUSH_W-1:0]  flush_cnt_nxt_s;
  err_code_e           code_s;
  logic                err_s;
  logic                done_s;
  logic                drop_s;
  logic                adv_s;
  logic                clear_s;
  logic                fire_s;
  logic                at_sol_s;
  logic                at_eol_s;
  logic                at_eof_s;
  logic                first_line_s;
  logic                at_sof_s;

  assign o_tdata  = i_tdata;
  assign o_tuser  = i_tuser;
  assign o_tlast  = i_tlast;
  assign at_sof_s = at_sol_s && first_line_s;
  assign fire_s   = i_tvalid && i_tready;

  // Position is held at (0,0) for the whole flush so SEEK always starts clean.
  assign clear_s  = (state_r == FLUSH);

  frame_pos_counter #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_pos (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .clear      (clear_s),
    .advance    (adv_s),
    .at_sol     (at_sol_s),
    .at_eol     (at_eol_s),
    .at_eof     (at_eof_s),
    .first_line (first_line_s)
  );

  // Next-state, handshake steering and per-beat framing checks.
  always_comb begin
    state_nxt_s     = state_r;
    flush_cnt_nxt_s = flush_cnt_r;
    o_tvalid        = 1'b0;
    o_tready        = 1'b0;
    code_s          = ERR_NO_SOF;
    err_s           = 1'b0;
    done_s          = 1'b0;
    drop_s          = 1'b0;
    adv_s           = 1'b0;

    case (state_r)
      SEEK: begin
        if (i_tuser) begin
          o_tvalid = i_tvalid;
          o_tready = i_tready;
          if (fire_s) begin
            adv_s       = 1'b1;
            state_nxt_s = ACTIVE;
          end else begin
            state_nxt_s = SEEK;
          end
        end else begin
          // Non-SOF beats are swallowed so upstream drains to the next frame.
          o_tready = 1'b1;
          drop_s   = i_tvalid;
        end
      end

      ACTIVE: begin
        if (i_tvalid && i_tuser && !at_sof_s) begin
          // Hold the stray SOF beat upstream; it is re-accepted from SEEK.
          err_s       = 1'b1;
          code_s      = ERR_UNEXP_SOF;
          state_nxt_s = FLUSH;
        end else begin
          o_tvalid = i_tvalid;
          o_tready = i_tready;
          if (fire_s) begin
            if (at_sof_s && !i_tuser) begin
              err_s  = 1'b1;
              code_s = ERR_NO_SOF;
            end else if (i_tlast && !at_eol_s) begin
              err_s  = 1'b1;
              code_s = ERR_EARLY_EOL;
            end else if (!i_tlast && at_eol_s) begin
              err_s  = 1'b1;
              code_s = ERR_NO_EOL;
            end else begin
              adv_s  = 1'b1;
              done_s = at_eof_s;
            end
          end else begin
            adv_s = 1'b0;
          end
          if (err_s) begin
            state_nxt_s = FLUSH;
          end else begin
            state_nxt_s = ACTIVE;
          end
        end
      end

      FLUSH: begin
        if (flush_cnt_r == FLUSH_LAST) begin
          state_nxt_s = SEEK;
        end else begin
          flush_cnt_nxt_s = flush_cnt_r + FLUSH_W'(1);
        end
      end

      default: begin
        state_nxt_s = SEEK;
      end
    endcase

    // External flush overrides any error or completion seen on this beat.
    if (i_flush) begin
      state_nxt_s = FLUSH;
      err_s       = 1'b0;
      done_s      = 1'b0;
    end else begin
      done_s = done_s && !err_s;
    end

    if (i_flush || ((state_nxt_s == FLUSH) && (state_r != FLUSH))) begin
      flush_cnt_nxt_s = {FLUSH_W{1'b0}};
    end else begin
      flush_cnt_nxt_s = flush_cnt_nxt_s;
    end
  end

  // State, flush counter and registered status outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r      <= SEEK;
      flush_cnt_r  <= {FLUSH_W{1'b0}};
      o_flush      <= 1'b0;
      o_err        <= 1'b0;
      o_err_code   <= 2'd0;
      o_frame_done <= 1'b0;
      o_frame_cnt  <= {FCNT_WIDTH{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      flush_cnt_r  <= flush_cnt_nxt_s;
      o_flush      <= (state_nxt_s == FLUSH);
      o_err        <= err_s;
      o_frame_done <= done_s;
      if (err_s) begin
        o_err_code <= code_s;
      end
      if (done_s) begin
        o_frame_cnt <= o_frame_cnt + FCNT_WIDTH'(1);
      end
    end
  end

`ifdef FRAME_STATS_EN
  logic [FCNT_WIDTH-1:0] err_cnt_r;
  logic [FCNT_WIDTH-1:0] drop_cnt_r;

  // Saturating error and discarded-beat statistics.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      err_cnt_r  <= {FCNT_WIDTH{1'b0}};
      drop_cnt_r <= {FCNT_WIDTH{1'b0}};
    end else begin
      if (err_s && (err_cnt_r != {FCNT_WIDTH{1'b1}})) begin
        err_cnt_r <= err_cnt_r + FCNT_WIDTH'(1);
      end
      if (drop_s && (drop_cnt_r != {FCNT_WIDTH{1'b1}})) begin
        drop_cnt_r <= drop_cnt_r + FCNT_WIDTH'(1);
      end
    end
  end

  assign o_err_cnt  = err_cnt_r;
  assign o_drop_cnt = drop_cnt_r;
`else
  logic unused_drop_s;
  assign unused_drop_s = drop_s;
  assign o_err_cnt     = {FCNT_WIDTH{1'b0}};
  assign o_drop_cnt    = {FCNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frame_sync_ctrl
// Randomised scoreboard bench for frame_sync_ctrl on a small 8x4 image.
// The stimulus side runs a transaction-level model (linear pixel index, seek or
// locked) and queues the expected forwarded beats, error/done events and flush
// lengths; a monitor process pops and compares when the DUT presents them.
// -----------------------------------------------------------------------------
module tb_frame_sync_ctrl;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int DW = 32;
  localparam int FC = 4;
  localparam int CW = 16;
  localparam int EV_DONE = 4;
  localparam int F_NONE  = 4;

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b0;
  logic          i_flush = 1'b0;
  logic [DW-1:0] i_tdata = '0;
  logic          i_tvalid = 1'b0;
  logic          i_tuser = 1'b0;
  logic          i_tlast = 1'b0;
  logic          i_tready = 1'b1;
  logic          o_tready, o_tvalid, o_tuser, o_tlast;
  logic [DW-1:0] o_tdata;
  logic          o_flush, o_frame_done, o_err;
  logic [1:0]    o_err_code;
  logic [CW-1:0] o_frame_cnt, o_err_cnt, o_drop_cnt;

  frame_sync_ctrl #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW),
    .FLUSH_CYCLES(FC), .FCNT_WIDTH(CW)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_flush(i_flush),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tuser(i_tuser), .i_tlast(i_tlast),
    .o_tready(o_tready), .o_tdata(o_tdata), .o_tvalid(o_tvalid),
    .o_tuser(o_tuser), .o_tlast(o_tlast), .i_tready(i_tready),
    .o_flush(o_flush), .o_frame_done(o_frame_done), .o_frame_cnt(o_frame_cnt),
    .o_err(o_err), .o_err_code(o_err_code), .o_err_cnt(o_err_cnt),
    .o_drop_cnt(o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  logic [DW+1:0] beat_q[$];
  int            ev_q[$];
  int            flush_q[$];

  // reference model state
  bit m_locked;
  int m_pos;
  int m_fcnt, m_ecnt, m_dcnt;
  bit stall_en;
  bit skip_flush;
  int run_len;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
  endfunction

  function automatic longint stat_exp(input int v);
`ifdef FRAME_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  function automatic void m_error(input int code);
    ev_q.push_back(code);
    flush_q.push_back(FC);
    m_ecnt   = sat(m_ecnt);
    m_locked = 1'b0;
    m_pos    = 0;
  endfunction

  function automatic void m_reset();
    m_locked = 1'b0;
    m_pos = 0;
    m_fcnt = 0;
    m_ecnt = 0;
    m_dcnt = 0;
  endfunction

  // Predict the fate of one beat, then offer it until the DUT takes it.
  task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l);
    bit fired;
    int n;
    if (m_locked && u && m_pos != 0) m_error(3);
    if (!m_locked) begin
      if (u) begin
        beat_q.push_back({u, l, d});
        m_locked = 1'b1;
        m_pos = 1;
      end else begin
        m_dcnt = sat(m_dcnt);
      end
    end else begin
      beat_q.push_back({u, l, d});
      if (m_pos == 0 && !u) m_error(0);
      else if (l && (m_pos % W) != W - 1) m_error(1);
      else if (!l && (m_pos % W) == W - 1) m_error(2);
      else begin
        m_pos++;
        if (m_pos == W * H) begin
          m_pos = 0;
          m_fcnt++;
          ev_q.push_back(EV_DONE);
        end
      end
    end
    fired = 1'b0;
    n = 0;
    while (!fired && n < 60) begin
      @(negedge i_clk);
      i_tvalid = 1'b1;
      i_tdata  = d;
      i_tuser  = u;
      i_tlast  = l;
      i_tready = stall_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
      #1;
      fired = (o_tready === 1'b1);
      n++;
    end
    if (!fired) chk("accept_timeout", 0, 1);
  endtask

  // Raster beats p0..p1-1 of a frame with an optional fault at (fx,fy).
  task automatic send_frame(input int fault, input int fx, input int fy,
                            input int p0, input int p1);
    for (int p = p0; p < p1; p++) begin
      int x = p % W;
      int y = p / W;
      logic u = (p == 0);
      logic l = (x == W - 1);
      if (fault == 0 && p == 0) u = 1'b0;
      if (fault == 1 && x == fx && y == fy) l = 1'b1;
      if (fault == 2 && x == W - 1 && y == fy) l = 1'b0;
      if (fault == 3 && x == fx && y == fy) u = 1'b1;
      send_beat($urandom, u, l);
    end
  endtask

  task automatic idle(input int n);
    @(negedge i_clk);
    i_tvalid = 1'b0;
    i_tuser  = 1'b0;
    i_tlast  = 1'b0;
    i_flush  = 1'b0;
    i_tready = 1'b1;
    repeat (n - 1) @(negedge i_clk);
  endtask

  task automatic flush_pulse(input int gap);
    @(negedge i_clk);
    i_tvalid = 1'b0;
    i_flush  = 1'b1;
    @(negedge i_clk);
    i_flush  = 1'b0;
    if (gap > 0) begin
      repeat (gap - 1) @(negedge i_clk);
      i_flush = 1'b1;
      @(negedge i_clk);
      i_flush = 1'b0;
    end
    m_locked = 1'b0;
    m_pos = 0;
    flush_q.push_back(FC + gap);
  endtask

  // Monitor: forwarded beats, error/done events and flush window lengths.
  always @(negedge i_clk) begin
    #2;
    if (o_tvalid === 1'b1 && i_tready === 1'b1) begin
      if (beat_q.size() == 0) chk("beat_unexpected", 1, 0);
      else begin
        logic [DW+1:0] e;
        e = beat_q.pop_front();
        chk("beat", {o_tuser, o_tlast, o_tdata}, e);
      end
    end
    if (o_err === 1'b1) begin
      if (ev_q.size() == 0) chk("err_unexpected", 1, 0);
      else chk("err_code", o_err_code, ev_q.pop_front());
    end
    if (o_frame_done === 1'b1) begin
      if (ev_q.size() == 0) chk("done_unexpected", 1, 0);
      else chk("frame_done", EV_DONE, ev_q.pop_front());
    end
    if (o_flush === 1'b1) begin
      run_len++;
      chk("flush_hs", {o_tready, o_tvalid}, 0);
    end else if (run_len > 0) begin
      if (skip_flush) skip_flush = 1'b0;
      else if (flush_q.size() == 0) chk("flush_unexpected", run_len, 0);
      else chk("flush_len", run_len, flush_q.pop_front());
      run_len = 0;
    end
  end

  task automatic check_counters(input string tag);
    chk({tag, "_frame_cnt"}, o_frame_cnt, m_fcnt % (1 << CW));
    chk({tag, "_err_cnt"}, o_err_cnt, stat_exp(m_ecnt));
    chk({tag, "_drop_cnt"}, o_drop_cnt, stat_exp(m_dcnt));
    chk({tag, "_beat_q"}, beat_q.size(), 0);
    chk({tag, "_ev_q"}, ev_q.size(), 0);
    chk({tag, "_flush_q"}, flush_q.size(), 0);
  endtask

  initial begin
    m_reset();
    stall_en = 1'b0;
    skip_flush = 1'b0;
    run_len = 0;
    #1;
    chk("rst_regs", {o_flush, o_err, o_frame_done, o_err_code}, 0);
    chk("rst_cnts", {o_frame_cnt, o_err_cnt, o_drop_cnt}, 0);
    repeat (3) @(negedge i_clk);
    i_rstn = 1'b1;

    // stream joins at line 1: everything dropped until the first SOF
    send_frame(F_NONE, 0, 0, W, W * H);
    // three clean frames, no back-pressure
    repeat (3) send_frame(F_NONE, 0, 0, 0, W * H);
    idle(3);
    check_counters("clean");

    // clean frame under random downstream stalls
    stall_en = 1'b1;
    send_frame(F_NONE, 0, 0, 0, W * H);
    // early EOL, missing EOL, missing SOF, stray SOF; each followed by a clean frame
    send_frame(1, 3, 1, 0, W * H);
    send_frame(F_NONE, 0, 0, 0, W * H);
    send_frame(2, 0, 2, 0, W * H);
    send_frame(F_NONE, 0, 0, 0, W * H);
    send_frame(3, 5, 2, 0, W * H);
    send_frame(F_NONE, 0, 0, 0, W * H);
    send_frame(F_NONE, 0, 0, 0, W * H);
    send_frame(0, 0, 0, 0, W * H);
    send_frame(F_NONE, 0, 0, 0, W * H);
    // external flush mid-frame, then a restarted flush
    send_frame(F_NONE, 0, 0, 0, 2 * W);
    flush_pulse(0);
    send_frame(F_NONE, 0, 0, 2 * W, W * H);
    send_frame(F_NONE, 0, 0, 0, W * H);
    flush_pulse(2);
    idle(8);
    check_counters("directed");

    // random fault mix
    for (int f = 0; f < 16; f++) begin
      int fault = $urandom_range(0, 6);
      int fx = $urandom_range(0, W - 2);
      int fy = $urandom_range(0, H - 1);
      if (fault == 3 && fx == 0 && fy == 0) fx = 1;
      send_frame((fault > 3) ? F_NONE : fault, fx, fy, 0, W * H);
    end
    send_frame(F_NONE, 0, 0, 0, W * H);
    send_frame(F_NONE, 0, 0, 0, W * H);
    idle(8);
    check_counters("random");

    // async reset in the middle of a flush
    send_frame(F_NONE, 0, 0, 0, W * H / 2);
    @(negedge i_clk);
    i_tvalid = 1'b0;
    i_flush = 1'b1;
    skip_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    @(negedge i_clk);
    #3;
    i_rstn = 1'b0;
    #1;
    chk("midrst_regs", {o_flush, o_err, o_frame_done}, 0);
    chk("midrst_cnts", {o_frame_cnt, o_err_cnt, o_drop_cnt}, 0);
    chk("midrst_seek_ready", o_tready, 1);
    m_reset();
    beat_q.delete();
    @(negedge i_clk);
    i_rstn = 1'b1;
    send_beat($urandom, 1'b0, 1'b0);
    send_frame(F_NONE, 0, 0, 0, W * H);
    idle(8);
    check_counters("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/frame_sync_ctrl.md
Name: frame_sync_ctrl

Overview:
Stream-integrity controller placed between the camera FIFO and the red-pixel processing datapath.
- Passes AXIS beats through with zero latency.
- Tracks pixel position (x,y) against IMG_WIDTH x IMG_HEIGHT.
- On a framing violation (bad SOF/EOL) or an external flush request, it:
  - pulses a multi-cycle flush to the datapath;
  - discards input until the next start-of-frame;
  - resumes forwarding from that SOF.
- Guarantees downstream centroid/crosshair logic only ever sees well-formed frames.

Parameters:
IMG_WIDTH, 640, pixels per line
IMG_HEIGHT, 480, lines per frame
DATA_WIDTH, 32, tdata width
FLUSH_CYCLES, 4, cycles o_flush held high per flush event (>=1)
FCNT_WIDTH, 16, width of frame/statistics counters

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_flush  in  1  synchronous external flush request
i_tdata  in  DATA_WIDTH  upstream pixel
i_tvalid  in  1  upstream valid
i_tuser  in  1  upstream SOF marker
i_tlast  in  1  upstream end-of-line
o_tready  out  1  ready to upstream
o_tdata  out  DATA_WIDTH  downstream pixel (= i_tdata)
o_tvalid  out  1  downstream valid
o_tuser  out  1  downstream SOF (= i_tuser)
o_tlast  out  1  downstream EOL (= i_tlast)
i_tready  in  1  downstream ready
o_flush  out  1  flush to processing datapath
o_frame_done  out  1  one-cycle pulse after last beat of a good frame
o_frame_cnt  out  FCNT_WIDTH  count of good frames, wraps
o_err  out  1  one-cycle error pulse
o_err_code  out  2  error cause, valid with o_err
o_err_cnt  out  FCNT_WIDTH  error count (see Optional Feature)
o_drop_cnt  out  FCNT_WIDTH  discarded-beat count (see Optional Feature)

Behaviour:
- Reset (i_rstn=0, async):
  - state=SEEK, x=y=0.
  - o_flush, o_frame_done, o_err=0; o_err_code=0.
  - o_frame_cnt, o_err_cnt, o_drop_cnt=0.
- Combinational outputs, zero latency: o_tdata, o_tuser, o_tlast, o_tvalid, o_tready.
- in_fire = i_tvalid & o_tready; out_fire = o_tvalid & i_tready.

States:
- SEEK:
  - Non-SOF beat: o_tvalid=0, o_tready=1 (beat dropped, drop_cnt++).
  - SOF beat: o_tvalid=1, o_tready=i_tready; on fire -> ACTIVE with x=1, y=0 (x=0, y=1 if IMG_WIDTH=1).
- ACTIVE: o_tvalid=i_tvalid, o_tready=i_tready, except for an unexpected SOF (see below). Checks on each beat:
  - Unexpected SOF (i_tuser=1 with (x,y)!=(0,0)): o_tvalid=0, o_tready=0, beat not consumed; o_err=1, code 3; -> FLUSH. The held SOF beat is accepted later from SEEK.
  - Missing SOF (fire at (0,0) with i_tuser=0): beat forwarded; code 0; -> FLUSH.
  - Early EOL (fire with i_tlast=1, x!=IMG_WIDTH-1): beat forwarded; code 1; -> FLUSH.
  - Missing EOL (fire with i_tlast=0, x=IMG_WIDTH-1): beat forwarded; code 2; -> FLUSH.
  - Good beat: x++; at x=IMG_WIDTH-1 set x=0, y++. At the final beat (IMG_WIDTH-1, IMG_HEIGHT-1) set x=y=0, o_frame_done=1 next cycle, frame_cnt++; stay ACTIVE.
- FLUSH:
  - o_flush=1, o_tvalid=0, o_tready=0 for exactly FLUSH_CYCLES cycles, then -> SEEK with x=y=0.
  - o_flush is registered: it rises the cycle after entry.
- i_flush=1 in any state:
  - -> FLUSH next cycle, no o_err.
  - Counter restarts if already in FLUSH.
  - Takes priority over a simultaneous error or frame completion; that beat still fires normally but the completion pulse is suppressed.
- Error and frame_done are mutually exclusive per beat.
- Counters wrap at 2^FCNT_WIDTH.
- Beats are never duplicated or reordered.
- Downstream stall (i_tready=0): outputs mirror held inputs, so stability is inherited from upstream.

Optional Feature:
FRAME_STATS_EN
- Defined: o_err_cnt increments on each o_err; o_drop_cnt increments on each beat discarded in SEEK. Both saturate at all-ones.
- Undefined: both outputs tied to 0 and no counter registers are synthesised.

Decomposition:
- Package frame_sync_pkg:
  - state enum {SEEK, ACTIVE, FLUSH};
  - error-code enum {ERR_NO_SOF=0, ERR_EARLY_EOL=1, ERR_NO_EOL=2, ERR_UNEXP_SOF=3};
  - width helpers X_W=$clog2(IMG_WIDTH), Y_W=$clog2(IMG_HEIGHT), FLUSH_W.
- Sub-module frame_pos_counter:
  - x/y counters with advance/clear inputs;
  - outputs at_sol, at_eol, at_eof.

Test Plan:
- Reset, then 3 clean 640x480 frames with i_tready=1 -> 921600 beats out unchanged, 3 o_frame_done pulses, o_frame_cnt=3, o_err never high.
- Clean frame with 30% random i_tready stalls -> output identical to input order, o_tready==i_tready throughout ACTIVE, frame_done once.
- Start stream at line 5 (no SOF) -> first 640*475 beats dropped (o_tvalid=0, o_drop_cnt=304000 with FRAME_STATS_EN), next SOF forwarded, one good frame.
- tlast at x=319 of line 10 -> beat forwarded, o_err=1 code 1, o_flush high 4 cycles, o_tready=0 during flush, then SEEK drops until next SOF.
- SOF injected at (100,200) -> that beat not accepted, o_err code 3, 4-cycle flush, same held beat then accepted from SEEK and a full frame completes.
- i_flush pulsed mid-frame at (0,240) -> o_flush 4 cycles, no o_err, frame_cnt unchanged; async reset asserted mid-flush -> all outputs 0 immediately, state SEEK.
